// File: rtl/riscv_pkg.sv
// riscv_pkg: shared integer-core widths and the writeback buffer entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;
  typedef struct packed {
    reg_idx_t rd;
    xlen_t    data;
  } wb_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; the reset clears the pointers so buffered entries are discarded
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic do_push, do_pop;
  // pointers carry one wrap bit so full and empty are distinguishable
  assign full_o  = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign empty_o = wptr_q == rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  always_comb begin
    do_push = push_i && !full_o;
    do_pop = pop_i && !empty_o;
    mem_d = mem_q;
    if (do_push) mem_d[wptr_q[AW-1:0]] = din_i;
    wptr_d = wptr_q + (AW+1)'(do_push);
    rptr_d = rptr_q + (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges ALU and buffered long-latency results onto the regfile write port
// and keeps a per-register busy scoreboard for decode hazard stalls.
module regfile_wb_ctrl
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_wr_en_i,
  input  logic [4:0]  alu_wr_port_i,
  input  logic [31:0] alu_wr_data_i,
  output logic        alu_stall_o,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rd_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  input  logic [4:0]  chk_port1_i,
  input  logic [4:0]  chk_port2_i,
  output logic        busy1_o,
  output logic        busy2_o,
  output logic [31:0] wr_data_o,
  output logic [4:0]  wr_port_o,
  output logic        ctrl_reg_wr_en_o,
  output logic        err_o
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  wb_entry_t head, push_ent;
  logic full, empty, push, pop, alu_ok, fifo_wr;
  logic wr_en_d, wr_en_q, src_fifo_q, err_d, err_q;
  reg_idx_t wr_port_d, wr_port_q;
  xlen_t wr_data_d, wr_data_q;
  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic [SW-1:0] starve_d, starve_q;
  assign push_ent = '{rd: lsu_rd_i, data: lsu_data_i};
  sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(wb_entry_t))) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );
  assign alu_stall_o      = starve_q == SW'(STARVE_MAX);
  assign lsu_ready_o      = !full;
  assign busy1_o          = busy_q[chk_port1_i];
  assign busy2_o          = busy_q[chk_port2_i];
  assign wr_data_o        = wr_data_q;
  assign wr_port_o        = wr_port_q;
  assign ctrl_reg_wr_en_o = wr_en_q;
  assign err_o            = err_q;
  always_comb begin
    push = lsu_valid_i && !full;
    alu_ok = alu_wr_en_i && alu_wr_port_i != '0 && !alu_stall_o;
    pop = !empty && !alu_ok;
    fifo_wr = pop && head.rd != '0;
    wr_en_d = alu_ok || fifo_wr;
    wr_port_d = alu_ok ? alu_wr_port_i : fifo_wr ? head.rd : wr_port_q;
    wr_data_d = alu_ok ? alu_wr_data_i : fifo_wr ? head.data : wr_data_q;
    // a stall cycle has alu_ok low, so the counter restarts on the forced drain
    starve_d = (alu_ok && !empty) ? starve_q + SW'(1) : '0;
    busy_d = busy_q;
    if (src_fifo_q) busy_d[wr_port_q] = 1'b0;
    if (iss_valid_i && iss_rd_i != '0) busy_d[iss_rd_i] = 1'b1;
    err_d = err_q || (iss_valid_i && busy_q[iss_rd_i])
          || (alu_wr_en_i && (busy_q[alu_wr_port_i] || alu_stall_o))
          || (push && lsu_rd_i != '0 && !busy_q[lsu_rd_i]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      src_fifo_q <= 1'b0;
      wr_port_q <= '0;
      wr_data_q <= '0;
      busy_q <= '0;
      starve_q <= '0;
      err_q <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      src_fifo_q <= fifo_wr;
      wr_port_q <= wr_port_d;
      wr_data_q <= wr_data_d;
      busy_q <= busy_d;
      starve_q <= starve_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed scenarios plus random traffic against a queue-based
// reference model of the writeback controller.
module tb_regfile_wb_ctrl;
  localparam int DEPTH = 2;
  localparam int STARVE_MAX = 8;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_en = 1'b0, iss_valid = 1'b0, lsu_valid = 1'b0;
  logic [4:0] alu_port = '0, iss_rd = '0, lsu_rd = '0, chk1 = '0, chk2 = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic alu_stall, lsu_ready, busy1, busy2, wr_en, err;
  logic [4:0] wr_port;
  logic [31:0] wr_data;
  int checks = 0, failures = 0;
  ent_t q[$];
  bit [31:0] mbusy = '0;
  int starve = 0;
  bit m_en = 0, m_src = 0, m_err = 0;
  logic [4:0] m_port = '0;
  logic [31:0] m_data = '0;
  always #5 clk = ~clk;
  regfile_wb_ctrl #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_wr_en_i      (alu_en),
    .alu_wr_port_i    (alu_port),
    .alu_wr_data_i    (alu_data),
    .alu_stall_o      (alu_stall),
    .iss_valid_i      (iss_valid),
    .iss_rd_i         (iss_rd),
    .lsu_valid_i      (lsu_valid),
    .lsu_ready_o      (lsu_ready),
    .lsu_rd_i         (lsu_rd),
    .lsu_data_i       (lsu_data),
    .chk_port1_i      (chk1),
    .chk_port2_i      (chk2),
    .busy1_o          (busy1),
    .busy2_o          (busy2),
    .wr_data_o        (wr_data),
    .wr_port_o        (wr_port),
    .ctrl_reg_wr_en_o (wr_en),
    .err_o            (err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  task automatic cmp_all();
    check("wr_en", wr_en, m_en);
    check("wr_port", wr_port, m_port);
    check("wr_data", wr_data, m_data);
    check("lsu_ready", lsu_ready, q.size() < DEPTH);
    check("alu_stall", alu_stall, starve == STARVE_MAX);
    check("busy1", busy1, mbusy[chk1]);
    check("busy2", busy2, mbusy[chk2]);
    check("err", err, m_err);
  endtask
  // advances the reference by one clock using the inputs currently applied
  task automatic model_step();
    bit stall, empty, accept, alu_ok;
    ent_t h;
    if (!rst_n) begin
      q.delete();
      mbusy = '0;
      starve = 0;
      m_en = 0;
      m_src = 0;
      m_err = 0;
      m_port = '0;
      m_data = '0;
      return;
    end
    stall = starve == STARVE_MAX;
    empty = q.size() == 0;
    accept = lsu_valid && q.size() < DEPTH;
    alu_ok = alu_en && alu_port != 0 && !stall;
    if ((iss_valid && mbusy[iss_rd]) || (alu_en && mbusy[alu_port]) || (alu_en && stall)
        || (accept && lsu_rd != 0 && !mbusy[lsu_rd])) m_err = 1;
    if (m_en && m_src) mbusy[m_port] = 0;
    if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1;
    starve = (alu_ok && !empty) ? starve + 1 : 0;
    m_en = 0;
    m_src = 0;
    if (alu_ok) begin
      m_en = 1;
      m_port = alu_port;
      m_data = alu_data;
    end else if (!empty) begin
      h = q.pop_front();
      if (h.rd != 0) begin
        m_en = 1;
        m_src = 1;
        m_port = h.rd;
        m_data = h.d;
      end
    end
    if (accept) q.push_back({lsu_rd, lsu_data});
  endtask
  task automatic cycle();
    #2;
    cmp_all();
    model_step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int stalls, k, r;
    bit acc;
    logic [4:0] owed[$];
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", lsu_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_err", err, 0);
    cycle();
    rst_n = 1'b1;
    cycle();
    // ALU write and x0 drop
    alu_en = 1; alu_port = 5; alu_data = 32'hDEADBEEF;
    cycle();
    alu_port = 0; alu_data = 32'h1;
    check("alu_en", wr_en, 1);
    check("alu_port", wr_port, 5);
    check("alu_data", wr_data, 32'hDEADBEEF);
    cycle();
    alu_en = 0;
    check("x0_no_strobe", wr_en, 0);
    check("x0_port_hold", wr_port, 5);
    check("x0_data_hold", wr_data, 32'hDEADBEEF);
    // LSU writeback through the buffer
    chk1 = 7; iss_valid = 1; iss_rd = 7;
    cycle();
    iss_valid = 0;
    check("lsu_busy_set", busy1, 1);
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
    cycle();
    lsu_valid = 0;
    check("lsu_n1_idle", wr_en, 0);
    cycle();
    check("lsu_en", wr_en, 1);
    check("lsu_port", wr_port, 7);
    check("lsu_data", wr_data, 32'h1234);
    check("lsu_busy_hold", busy1, 1);
    cycle();
    check("lsu_busy_clr", busy1, 0);
    // ALU beats a pending buffered result
    chk2 = 9; iss_valid = 1; iss_rd = 9;
    cycle();
    iss_valid = 0; lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    cycle();
    lsu_valid = 0; alu_en = 1; alu_port = 3; alu_data = 32'h33;
    cycle();
    alu_en = 0;
    check("conf_first_port", wr_port, 3);
    check("conf_first_data", wr_data, 32'h33);
    cycle();
    check("conf_second_en", wr_en, 1);
    check("conf_second_port", wr_port, 9);
    check("conf_second_data", wr_data, 32'h99);
    cycle();
    check("conf_busy_clr", busy2, 0);
    // result for x0 is accepted but never strobed
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h55;
    cycle();
    lsu_valid = 0;
    cycle();
    check("rd0_no_strobe", wr_en, 0);
    cycle();
    // backpressure with a continuously writing ALU
    chk1 = 12;
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1; iss_rd = 5'(10 + i);
      cycle();
    end
    iss_valid = 0;
    stalls = 0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      alu_en = starve != STARVE_MAX; alu_port = 20; alu_data = 32'(i);
      lsu_valid = k < 3; lsu_rd = 5'(10 + k); lsu_data = 32'(100 + k);
      acc = lsu_valid && q.size() < DEPTH;
      if (i == 2) check("bp_ready_low", lsu_ready, 0);
      if (i == 9) check("bp_stall_9", alu_stall, 1);
      stalls += int'(alu_stall);
      cycle();
      if (acc) k++;
    end
    check("bp_stalls", stalls, 2);
    check("bp_accepts", k, 3);
    alu_en = 0; lsu_valid = 0;
    repeat (5) cycle();
    check("bp_busy_clr", busy1, 0);
    check("bp_no_err", err, 0);
    // violation: issue to an already-busy register
    chk1 = 4; iss_valid = 1; iss_rd = 4;
    cycle();
    cycle();
    iss_valid = 0;
    check("viol_err", err, 1);
    repeat (3) cycle();
    check("viol_sticky", err, 1);
    check("viol_busy", busy1, 1);
    rst_n = 0;
    repeat (2) cycle();
    rst_n = 1;
    cycle();
    check("viol_rst_err", err, 0);
    check("viol_rst_busy", busy1, 0);
    // reset with two results buffered behind ALU traffic
    chk1 = 13; chk2 = 14;
    iss_valid = 1; iss_rd = 13;
    cycle();
    iss_rd = 14;
    cycle();
    iss_valid = 0; alu_en = 1; alu_port = 21;
    lsu_valid = 1; lsu_rd = 13; lsu_data = 32'hA13;
    cycle();
    lsu_rd = 14; lsu_data = 32'hA14;
    cycle();
    lsu_valid = 0; alu_en = 0; rst_n = 0;
    cycle();
    repeat (2) begin
      cycle();
      check("rst_mid_no_strobe", wr_en, 0);
    end
    rst_n = 1;
    repeat (4) begin
      cycle();
      check("post_rst_no_strobe", wr_en, 0);
      check("post_rst_ready", lsu_ready, 1);
      check("post_rst_busy1", busy1, 0);
      check("post_rst_busy2", busy2, 0);
    end
    // random legal traffic
    for (int i = 0; i < 400; i++) begin
      if (!lsu_valid && owed.size() > 0 && $urandom_range(1) == 1) begin
        lsu_valid = 1;
        lsu_rd = owed.pop_front();
        lsu_data = $urandom;
      end
      iss_valid = $urandom_range(3) == 0;
      r = $urandom_range(31);
      iss_rd = mbusy[r] ? 5'd0 : 5'(r);
      if (iss_valid) owed.push_back(iss_rd);
      alu_en = $urandom_range(1) == 1 && starve != STARVE_MAX;
      r = $urandom_range(31);
      alu_port = mbusy[r] ? 5'd0 : 5'(r);
      alu_data = $urandom;
      chk1 = 5'($urandom_range(31));
      chk2 = 5'($urandom_range(31));
      acc = lsu_valid && q.size() < DEPTH;
      cycle();
      if (acc) lsu_valid = 0;
    end
    check("rand_no_err", err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller and scoreboard that drives the write port of the integer register file. It merges single-cycle ALU results with results from long-latency units (LSU, divider) that arrive through a valid/ready handshake. Pending long-latency results are buffered, and a busy bit is tracked per architectural register so the decode stage can stall on RAW/WAW hazards. It sits between the execute stage and `regfile`, and is the only writer of `regfile`.

## Interface
- `DEPTH`, 2: long-latency result buffer entries (power of two, ≥2)
- `STARVE_MAX`, 8: consecutive ALU wins, with results pending, before the ALU is stalled
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `alu_wr_en_i`  in  1  ALU result valid this cycle
- `alu_wr_port_i`  in  5  ALU destination register
- `alu_wr_data_i`  in  32  ALU result
- `alu_stall_o`  out  1  pipeline must not present an ALU write this cycle
- `iss_valid_i`  in  1  long-latency op issued this cycle
- `iss_rd_i`  in  5  its destination register
- `lsu_valid_i`  in  1  long-latency result valid
- `lsu_ready_o`  out  1  buffer can accept
- `lsu_rd_i`  in  5  result destination
- `lsu_data_i`  in  32  result data
- `chk_port1_i`, `chk_port2_i`  in  5  decode source registers
- `busy1_o`, `busy2_o`  out  1  the corresponding source has a pending write
- `wr_data_o`  out  32  to `regfile` `wr_data_i`
- `wr_port_o`  out  5  to `regfile` `wr_port_i`
- `ctrl_reg_wr_en_o`  out  1  to `regfile` `ctrl_reg_wr_en_i`
- `err_o`  out  1  sticky protocol-violation flag

## Operation
- **Accept:** `lsu_ready_o = !full`. A result is accepted when `lsu_valid_i & lsu_ready_o`, and is pushed into the FIFO.
- **Output stage:** registered; loaded each cycle by priority.
  1. ALU, if `alu_wr_en_i` and the port is not 0.
  2. Otherwise the FIFO head, if non-empty; the head is popped.
  3. Otherwise the strobe is 0.
- **Strobe payload:** `ctrl_reg_wr_en_o` is high for exactly one cycle per write. `wr_port_o` and `wr_data_o` hold their last values when the strobe is low.
- **x0:**
  - An ALU write to x0 is dropped; no strobe.
  - An LSU result with rd 0 is accepted and pushed, and is discarded at pop; no strobe.
  - Busy bit 0 is never set.
- **Scoreboard:**
  - `busy[iss_rd_i]` is set on `iss_valid_i` (rd ≠ 0).
  - `busy[p]` is cleared the cycle after a FIFO-sourced strobe to p.
  - If set and clear hit the same register in the same cycle, set wins.
  - `busyN_o = busy[chk_portN_i]`, combinational; 0 for port 0.
- **Starvation:**
  - A counter increments each cycle in which the ALU wins while the FIFO is non-empty. It resets on any FIFO pop or when the FIFO is empty.
  - When it reaches `STARVE_MAX`, `alu_stall_o` = 1 for one cycle, the FIFO head is forced out, and the counter resets.
- **`err_o`:** set, and held until reset, when any of the following occurs:
  - `iss_valid_i` targets a busy register;
  - `alu_wr_en_i` targets a busy register;
  - `alu_wr_en_i` is high while `alu_stall_o` is high (the ALU write is dropped);
  - `lsu_rd_i` is nonzero and its busy bit is clear at accept.
- **Reset:** all outputs 0 except `lsu_ready_o` = 1. FIFO empty, busy vector 0, starvation counter 0, `err_o` 0. Reset mid-transfer discards buffered results; no strobes occur during reset.

## Timing
- ALU write presented in cycle N: strobe in cycle N+1.
- LSU result accepted in cycle N with an empty FIFO and no ALU write in N+1: strobe in N+2.
- Busy clears in N+3 in that case. `regfile` is write-through, so a dependent read is correct from the clearing cycle.
- FIFO full: `lsu_ready_o` = 0. A simultaneous pop does not raise ready in the same cycle; ready returns the next cycle.
- Throughput: one strobe per cycle; one accept per cycle while not full.
- `alu_stall_o` is combinational from the counter register; it is asserted in the same cycle as the forced FIFO drain.

## Structure
- Shared package `riscv_pkg`: `XLEN` = 32, `REG_ADDR_W` = 5, `NUM_REGS` = 32; width typedefs for register index and data.
- Sub-module `sync_fifo`: `DEPTH` × 37 bits ({rd, data}), with push, pop, full, empty and synchronous active-low reset. It is reusable by the LSU.
- Top level contains the priority mux, output register, busy vector, starvation counter and error logic.

## Test plan
- **ALU only:** ALU write x5 = 0xDEADBEEF in cycle 1 → strobe in cycle 2 with port 5 and the data. ALU write to x0 → no strobe.
- **LSU writeback:** issue rd = 7; `busy1_o` = 1 for `chk_port1_i` = 7. Result 0x1234 accepted → strobe to port 7 two cycles later, then busy clears.
- **Conflict:** ALU write x3 and a pending LSU result for x9 in the same cycle → x3 strobe first, then x9 the next cycle.
- **Backpressure:** hold the ALU writing for 20 cycles with `DEPTH` = 2 and three LSU results offered.
  - `lsu_ready_o` drops after 2 accepts.
  - `alu_stall_o` pulses after 8 ALU wins, draining one entry per pulse.
- **Violations:** issue to an already-busy x4 → `err_o` = 1 and remains 1. Reset → `err_o` = 0 and busy vector 0.
- **Reset mid-operation:** reset with 2 buffered results → no strobes during or after reset, `lsu_ready_o` = 1, all `busyN_o` = 0.
